vector_transpose_buf: RTL

- Parametrised row-to-column transpose buffer for the vector lane datapath.
- Fill phase: accepts up to ROWS row vectors of LANES elements each.
- Drain phase: emits LANES column vectors of ROWS elements each.
- Compared with the fixed 8-lane/2-row transposer, this block adds:
  - valid/ready handshakes on both sides;
  - early termination (partial fill, with zero-padded rows);
  - a reported valid-row count;
  - a synchronous flush.

---
 rtl/vector_transpose_buf.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/vector_transpose_buf.sv
// Row-to-column transpose buffer: fills up to ROWS rows of LANES elements, then drains
// LANES columns of ROWS elements, with valid/ready on both sides, early termination and flush.
module vector_transpose_buf #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned LANES = 8,
    parameter int unsigned ROWS  = 2,
    parameter int unsigned CW    = $clog2(ROWS + 1)
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ROWS*WIDTH-1:0]  out_data,
    output logic                   out_last,
    output logic [CW-1:0]          out_rows,
    output logic                   busy
);

    localparam int unsigned LW = $clog2(LANES);

    typedef enum logic {
        StFill,
        StDrain
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   row_cnt_q, row_cnt_d;
    logic [LW-1:0]   col_cnt_q, col_cnt_d;
    logic [CW-1:0]   nrows_q, nrows_d;
    logic [WIDTH-1:0] mem_q [LANES][ROWS];

    logic in_fire;
    logic out_fire;
    logic last_row;
    logic last_col;

    // flush wins over both handshakes in the same cycle
    assign in_fire  = (state_q == StFill) && in_valid && !flush;
    assign out_fire = (state_q == StDrain) && out_ready && !flush;
    assign last_row = in_last || (row_cnt_q == CW'(ROWS - 1));
    assign last_col = (col_cnt_q == LW'(LANES - 1));

    always_comb begin
        state_d   = state_q;
        row_cnt_d = row_cnt_q;
        col_cnt_d = col_cnt_q;
        nrows_d   = nrows_q;
        if (flush) begin
            state_d   = StFill;
            row_cnt_d = '0;
            col_cnt_d = '0;
            nrows_d   = '0;
        end else begin
            unique case (state_q)
                StFill: begin
                    if (in_fire) begin
                        if (last_row) begin
                            state_d   = StDrain;
                            nrows_d   = row_cnt_q + CW'(1);
                            row_cnt_d = '0;
                        end else begin
                            row_cnt_d = row_cnt_q + CW'(1);
                        end
                    end
                end
                StDrain: begin
                    if (out_fire) begin
                        if (last_col) begin
                            state_d   = StFill;
                            col_cnt_d = '0;
                            nrows_d   = '0;
                        end else begin
                            col_cnt_d = col_cnt_q + LW'(1);
                        end
                    end
                end
                default: state_d = StFill;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StFill;
            row_cnt_q <= '0;
            col_cnt_q <= '0;
            nrows_q   <= '0;
        end else begin
            state_q   <= state_d;
            row_cnt_q <= row_cnt_d;
            col_cnt_q <= col_cnt_d;
            nrows_q   <= nrows_d;
        end
    end

    // Terminating row also zero-pads every later row so short blocks drain clean
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int l = 0; l < LANES; l++) begin
                for (int r = 0; r < ROWS; r++) begin
                    mem_q[l][r] <= '0;
                end
            end
        end else if (flush) begin
            for (int l = 0; l < LANES; l++) begin
                for (int r = 0; r < ROWS; r++) begin
                    mem_q[l][r] <= '0;
                end
            end
        end else if (in_fire) begin
            for (int l = 0; l < LANES; l++) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (CW'(r) == row_cnt_q) begin
                        mem_q[l][r] <= in_data[l*WIDTH +: WIDTH];
                    end else if (last_row && (CW'(r) > row_cnt_q)) begin
                        mem_q[l][r] <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        if (state_q == StDrain) begin
            for (int r = 0; r < ROWS; r++) begin
                out_data[r*WIDTH +: WIDTH] = mem_q[col_cnt_q][r];
            end
        end
    end

    assign in_ready  = (state_q == StFill);
    assign out_valid = (state_q == StDrain);
    assign busy      = (state_q == StDrain);
    assign out_last  = (state_q == StDrain) && last_col;
    assign out_rows  = nrows_q;

endmodule
